// File: rtl/half_life_ctrl.sv
// half_life_ctrl: drives load/down commands into an external N-bit counter,
// steps it down once per prescaled period, and reports a half-life event
// each time the returned count meets the current (halving) threshold.
module half_life_ctrl #(
   parameter int N  = 4,
   parameter int PW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic [N-1:0]  init,
   input  logic [PW-1:0] period,
   input  logic [N-1:0]  cnt_out,
   output logic          cnt_clr,
   output logic          cnt_up,
   output logic          cnt_down,
   output logic          cnt_load,
   output logic [N-1:0]  cnt_in,
   output logic          busy,
   output logic          done,
   output logic          half_pulse,
   output logic [N-1:0]  halves
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT,
      S_STEP,
      S_CHECK,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  init_q,  init_d;
   logic [PW-1:0] per_q,   per_d;
   logic [N-1:0]  thr_q,   thr_d;
   logic [PW-1:0] pre_q,   pre_d;
   logic [N-1:0]  halves_q, halves_d;

   logic          busy_c;
   logic          load_c;
   logic          down_c;
   logic          half_c;
   logic          clr_c;
   logic [PW-1:0] pre_reload;

   // A zero period behaves like one, so the prescaler reload never underflows.
   assign pre_reload = (per_q == '0) ? '0 : per_q - 1'b1;

   // Next-state and command decode; abort overrides whatever the state chose.
   always_comb begin
      // NOTE: every signal written here gets a default first so no latch is inferred.
      state_d  = state_q;
      init_d   = init_q;
      per_d    = per_q;
      thr_d    = thr_q;
      pre_d    = pre_q;
      halves_d = halves_q;
      load_c   = 1'b0;
      down_c   = 1'b0;
      half_c   = 1'b0;
      clr_c    = 1'b0;
      busy_c   = (state_q == S_LOAD) || (state_q == S_WAIT) ||
                 (state_q == S_STEP) || (state_q == S_CHECK);

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               init_d   = init;
               per_d    = period;
               thr_d    = init >> 1;
               halves_d = '0;
               state_d  = S_LOAD;
            end
         end
         S_LOAD: begin
            load_c = 1'b1;
            if (init_q == '0) begin
               state_d = S_DONE;
            end else begin
               pre_d   = pre_reload;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (pre_q == '0) begin
               state_d = S_STEP;
            end else begin
               pre_d = pre_q - 1'b1;
            end
         end
         S_STEP: begin
            down_c  = 1'b1;
            state_d = S_CHECK;
         end
         S_CHECK: begin
            // The counter already reflects the STEP decrement in this cycle.
            if ((cnt_out == thr_q) && (thr_q != '0)) begin
               half_c   = 1'b1;
               halves_d = (&halves_q) ? halves_q : halves_q + 1'b1;
               thr_d    = thr_q >> 1;
            end
            if (cnt_out == '0) begin
               state_d = S_DONE;
            end else begin
               pre_d   = pre_reload;
               state_d = S_WAIT;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Abort discards every pending update except the return to IDLE.
      if (busy_c && abort) begin
         state_d  = S_IDLE;
         init_d   = init_q;
         per_d    = per_q;
         thr_d    = thr_q;
         pre_d    = pre_q;
         halves_d = halves_q;
         load_c   = 1'b0;
         down_c   = 1'b0;
         half_c   = 1'b0;
         clr_c    = 1'b1;
      end
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!rst) begin
         state_q  <= S_IDLE;
         init_q   <= '0;
         per_q    <= '0;
         thr_q    <= '0;
         pre_q    <= '0;
         halves_q <= '0;
      end else begin
         state_q  <= state_d;
         init_q   <= init_d;
         per_q    <= per_d;
         thr_q    <= thr_d;
         pre_q    <= pre_d;
         halves_q <= halves_d;
      end
   end

   // Outputs are forced quiet during reset, except the counter clear which
   // must be asserted so the counter clears on the same edge.
   always_comb begin
      cnt_up     = 1'b0;
      cnt_clr    = !rst || clr_c;
      cnt_load   = rst && load_c;
      cnt_down   = rst && down_c;
      half_pulse = rst && half_c;
      busy       = rst && busy_c;
      done       = rst && (state_q == S_DONE);
      cnt_in     = rst ? init_q   : '0;
      halves     = rst ? halves_q : '0;
   end

endmodule

// File: doc/half_life_ctrl.md
# half_life_ctrl

Sequencer that drives the command side of the timer's N-bit up/down/load counter and reads its count back. On `start` it loads an initial quantity into the counter. It then issues one `down` command per prescaled period and watches the returned count. Each time the count reaches the current half-threshold it emits a half-life event and halves the threshold. It stops when the count reaches zero. It sits between the timer's user controls/display and the counter instance.

## Interface
- `N`, default 4: counter width; width of `init`, `cnt_in`, `cnt_out`, `halves`.
- `PW`, default 8: prescaler width; width of `period`.

- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  begin run; sampled in IDLE or DONE only.
- `abort`  in  1  cancel run; sampled in LOAD/WAIT/STEP/CHECK.
- `init`  in  N  initial quantity; captured on accepted `start`.
- `period`  in  PW  clock cycles per WAIT; captured on accepted `start`; 0 is treated as 1.
- `cnt_out`  in  N  current counter value (counter output).
- `cnt_clr`  out  1  counter reset command (active-high, counter's top-priority input).
- `cnt_up`  out  1  counter increment command; held 0 by this block.
- `cnt_down`  out  1  counter decrement command.
- `cnt_load`  out  1  counter load command.
- `cnt_in`  out  N  load value; equals captured `init`.
- `busy`  out  1  high in LOAD, WAIT, STEP, CHECK.
- `done`  out  1  high while in DONE.
- `half_pulse`  out  1  one-cycle half-life event.
- `halves`  out  N  half-life events this run; saturates at all-ones.

## Operation
- Counter contract: a command presented in cycle t is reflected on `cnt_out` in cycle t+1. At most one of `cnt_clr/cnt_down/cnt_load` is high in any cycle.
- Registers:
  - `init_q`, `per_q`: captured on accepted `start`.
  - `thr`: threshold, N bits.
  - `pre`: prescaler, PW bits.
  - `halves`.
- States:
  - IDLE: outputs 0.
    - `start`: capture `init_q`/`per_q`; `thr <= init>>1`; `halves <= 0`; go to LOAD.
  - LOAD: `cnt_load=1`; `cnt_in=init_q`.
    - If `init_q==0`, go to DONE.
    - Else `pre <= max(per_q,1)-1`; go to WAIT.
  - WAIT: decrement `pre`. At `pre==0`, go to STEP.
  - STEP: `cnt_down=1` for exactly one cycle; go to CHECK.
  - CHECK: evaluate `cnt_out`, which is already updated.
    - If `cnt_out==thr && thr!=0`: `half_pulse=1`; `halves <= sat(halves+1)`; `thr <= thr>>1`.
    - Then, if `cnt_out==0`, go to DONE.
    - Else reload `pre`; go to WAIT.
  - DONE: `done=1`; `cnt_out`, `halves` and `thr` are held.
    - `start` restarts exactly as from IDLE, going to LOAD.
- `abort` in any busy state: `cnt_clr=1` that cycle; next state IDLE; `halves` is held. `abort` has priority over every transition.
- `start` while busy is ignored. `abort` in IDLE/DONE is ignored.
- Reset: while `rst==0`, `cnt_clr=1` combinationally, so the counter clears in the same edge. All other outputs are 0. Next state IDLE; `halves`, `thr`, `pre`, `init_q`, `per_q` become 0. Reset mid-run abandons the run with no `done` and no `half_pulse`.
- Width rules:
  - `thr` is a logical right shift.
  - Comparisons are unsigned N-bit.
  - `cnt_out` never wraps, because no `down` is issued at 0.

## Timing
- Reset value of every output is 0, except `cnt_clr=1` during reset.
- Accepted `start` at edge k: LOAD in cycle k+1, first WAIT in k+2.
- One decrement step is max(`period`,1)+2 cycles (WAIT×P, STEP, CHECK).
- `half_pulse` and the `halves` update occur in the CHECK cycle following the matching decrement.
- `done` rises in the cycle after the CHECK (or LOAD, when `init==0`) that sees zero.
- Total run for `init`=I>0, `period`=P: 1 + I×(P+2) cycles from LOAD to last CHECK.

## Test plan
- Reset: hold `rst=0` 3 cycles, then release.
  - During reset: `cnt_clr=1`, all other outputs 0.
  - After release: IDLE, `busy=0`, `halves=0`.
- Full run: `init=8`, `period=2`, with the counter model attached.
  - `cnt_load` for one cycle with `cnt_in=8`.
  - 8 `cnt_down` pulses, spaced 4 cycles apart.
  - `half_pulse` at counts 4, 2, 1; `halves=3`.
  - `done` rises 1 + 8×4 = 33 cycles after LOAD.
- `init=0`: `start` gives one LOAD cycle, then DONE; `halves=0`; no `cnt_down` ever.
- `period=0` with `init=3`: behaves identically to `period=1`, i.e. 3-cycle steps.
- Abort: abort during WAIT after 2 decrements of `init=8`.
  - `cnt_clr=1` for one cycle, then IDLE; `busy=0`; `done=0`.
  - `start` during the run is ignored; a new `start` from IDLE runs cleanly.
- Saturation and restart: `N=2`, `init=3`.
  - Halves event at count 1 only; `halves=1`.
  - `start` while in DONE reloads and reruns without passing through IDLE.
